// File: rtl/fsk_frame_sync.sv
// FSK frame synchroniser: recovers bit timing from the demodulated stream, hunts for
// SYNC_WORD and deframes length-prefixed packets with a modulo-256 checksum.
//
// state   | meaning
// HUNT    | searching the sampled bit stream for SYNC_WORD
// LEN     | receiving the length byte
// PAYLOAD | receiving payload bytes, each presented on byte_out
// CHK     | receiving the checksum byte
module fsk_frame_sync #(
    parameter int unsigned SAMPLES_PER_BIT = 16,
    parameter logic [15:0] SYNC_WORD       = 16'hD391,
    parameter int unsigned MAX_LEN         = 64
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       bit_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       locked
);
    localparam int unsigned   PW      = $clog2(SAMPLES_PER_BIT);
    localparam logic [PW-1:0] PH_LAST = PW'(SAMPLES_PER_BIT - 1);
    localparam logic [PW-1:0] PH_MID  = PW'(SAMPLES_PER_BIT / 2);
    localparam int unsigned   CW      = $clog2(MAX_LEN + 1);
    localparam logic [7:0]    MAX_L   = 8'(MAX_LEN);

    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK} state_t;

    state_t        state, state_nxt;
    logic          sync_1, bit_s, bit_d;
    logic          bit_edge, bit_stb;
    logic [PW-1:0] phase;
    logic [15:0]   sr, sr_nxt, sr_shift;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [CW-1:0] rem, rem_nxt;
    logic [7:0]    sum, sum_nxt;
    logic [7:0]    rx_byte, byte_out_nxt;
    logic          byte_done;
    logic          byte_valid_nxt, frame_start_nxt, frame_done_nxt, frame_ok_nxt;

    assign bit_edge = bit_s ^ bit_d;
    // A transition resets the phase and suppresses a strobe landing in the same cycle.
    assign bit_stb  = (phase == PH_MID) && !bit_edge;
    assign locked   = (state != S_HUNT);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_1 <= 1'b0;
            bit_s  <= 1'b0;
            bit_d  <= 1'b0;
            phase  <= '0;
        end else begin
            sync_1 <= bit_in;
            bit_s  <= sync_1;
            bit_d  <= bit_s;
            if (bit_edge || phase == PH_LAST)
                phase <= '0;
            else
                phase <= phase + PW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= S_HUNT;
            sr          <= '0;
            bit_cnt     <= '0;
            rem         <= '0;
            sum         <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            bit_cnt     <= bit_cnt_nxt;
            rem         <= rem_nxt;
            sum         <= sum_nxt;
            byte_out    <= byte_out_nxt;
            byte_valid  <= byte_valid_nxt;
            frame_start <= frame_start_nxt;
            frame_done  <= frame_done_nxt;
            frame_ok    <= frame_ok_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        sr_nxt          = sr;
        bit_cnt_nxt     = bit_cnt;
        rem_nxt         = rem;
        sum_nxt         = sum;
        byte_out_nxt    = byte_out;
        byte_valid_nxt  = 1'b0;
        frame_start_nxt = 1'b0;
        frame_done_nxt  = 1'b0;
        frame_ok_nxt    = 1'b0;
        sr_shift        = {sr[14:0], bit_s};
        rx_byte         = sr_shift[7:0];
        byte_done       = bit_stb && (bit_cnt == 3'd7);

        if (bit_stb) begin
            sr_nxt = sr_shift;
            if (state != S_HUNT)
                bit_cnt_nxt = bit_cnt + 3'd1;
        end

        case (state)
            S_HUNT: begin
                if (bit_stb && sr_shift == SYNC_WORD) begin
                    state_nxt       = S_LEN;
                    frame_start_nxt = 1'b1;
                    bit_cnt_nxt     = '0;
                    sum_nxt         = '0;
                end
            end
            S_LEN: begin
                if (byte_done) begin
                    sum_nxt = rx_byte;
                    if (rx_byte > MAX_L) begin
                        frame_done_nxt = 1'b1;
                        state_nxt      = S_HUNT;
                        sr_nxt         = '0;
                    end else if (rx_byte == 8'd0) begin
                        state_nxt = S_CHK;
                    end else begin
                        state_nxt = S_PAYLOAD;
                        rem_nxt   = CW'(rx_byte);
                    end
                end
            end
            S_PAYLOAD: begin
                if (byte_done) begin
                    byte_out_nxt   = rx_byte;
                    byte_valid_nxt = 1'b1;
                    sum_nxt        = sum + rx_byte;
                    rem_nxt        = rem - CW'(1);
                    if (rem == CW'(1))
                        state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (byte_done) begin
                    frame_done_nxt = 1'b1;
                    frame_ok_nxt   = (rx_byte == sum);
                    state_nxt      = S_HUNT;
                    sr_nxt         = '0;
                end
            end
            default: state_nxt = S_HUNT;
        endcase
    end
endmodule

// File: tb/tb_fsk_frame_sync.sv
// Directed bench for fsk_frame_sync: table of frames plus hand-written reset and
// false-sync sequences.
module tb_fsk_frame_sync;
    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       bit_in;
    logic [7:0] byte_out;
    logic       byte_valid, frame_start, frame_done, frame_ok, locked;

    int checks = 0;
    int errors = 0;

    fsk_frame_sync #(
        .SAMPLES_PER_BIT(16),
        .SYNC_WORD      (16'hD391),
        .MAX_LEN        (64)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .bit_in     (bit_in),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .locked     (locked)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0]  len;
        logic [31:0] pl;       // payload bytes, left-aligned, first byte in [31:24]
        int          npl;      // payload bytes transmitted
        logic [7:0]  chk;
        bit          send_chk;
        int          per_a;    // bit periods alternate per_a, per_b, per_a, ...
        int          per_b;
        int          exp_nb;
        logic        exp_ok;
    } vec_t;

    logic [7:0] got_bytes[$];
    logic       got_ok[$];
    int         n_start = 0;
    int         n_locked = 0;
    int         n_wide = 0;
    logic       pv_bv = 1'b0, pv_fs = 1'b0, pv_fd = 1'b0;
    int         tx_idx = 0;

    always @(posedge sys_clk) begin
        #1;
        if (byte_valid) got_bytes.push_back(byte_out);
        if (frame_done) got_ok.push_back(frame_ok);
        if (frame_start) n_start++;
        if (locked) n_locked++;
        if ((byte_valid && pv_bv) || (frame_start && pv_fs) || (frame_done && pv_fd)) n_wide++;
        pv_bv = byte_valid;
        pv_fs = frame_start;
        pv_fd = frame_done;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        got_bytes.delete();
        got_ok.delete();
        n_start  = 0;
        n_locked = 0;
    endtask

    task automatic send_bit(input logic b, input int pa, input int pb);
        bit_in = b;
        repeat ((tx_idx % 2 == 0) ? pa : pb) @(negedge sys_clk);
        tx_idx++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int pa, input int pb);
        for (int i = 7; i >= 0; i--) send_bit(b[i], pa, pb);
    endtask

    task automatic send_header(input logic [7:0] len, input int pa, input int pb);
        send_byte(8'hAA, pa, pb);
        send_byte(8'hAA, pa, pb);
        send_byte(8'hD3, pa, pb);
        send_byte(8'h91, pa, pb);
        send_byte(len, pa, pb);
    endtask

    task automatic send_frame(input vec_t v);
        send_header(v.len, v.per_a, v.per_b);
        for (int i = 0; i < v.npl; i++) send_byte(v.pl[31-8*i -: 8], v.per_a, v.per_b);
        if (v.send_chk) send_byte(v.chk, v.per_a, v.per_b);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 16, 16);
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        check({tag, ".start"}, n_start, 1);
        check({tag, ".nbytes"}, got_bytes.size(), v.exp_nb);
        for (int i = 0; i < got_bytes.size() && i < v.exp_nb; i++)
            check($sformatf("%s.byte%0d", tag, i), {24'd0, got_bytes[i]}, {24'd0, v.pl[31-8*i -: 8]});
        check({tag, ".ndone"}, got_ok.size(), 1);
        if (got_ok.size() > 0) check({tag, ".ok"}, {31'd0, got_ok[0]}, {31'd0, v.exp_ok});
        check({tag, ".unlocked"}, {31'd0, locked}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [15:0] win;
        logic [15:0] fake;
        logic        b;

        vecs[0] = '{8'h02, 32'h1234_0000, 2, 8'h48, 1'b1, 16, 16, 2, 1'b1};
        vecs[1] = '{8'h02, 32'h1234_0000, 2, 8'h49, 1'b1, 16, 16, 2, 1'b0};
        vecs[2] = '{8'h00, 32'h0000_0000, 0, 8'h00, 1'b1, 16, 16, 0, 1'b1};
        vecs[3] = '{8'h41, 32'h0000_0000, 0, 8'h00, 1'b0, 16, 16, 0, 1'b0};
        vecs[4] = '{8'h04, 32'hA55A_FF00, 4, 8'h02, 1'b1, 15, 17, 4, 1'b1};
        vecs[5] = '{8'h04, 32'hA55A_FF00, 4, 8'h02, 1'b1, 17, 15, 4, 1'b1};

        sys_rst = 1'b1;
        bit_in  = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("reset.byte_out", {24'd0, byte_out}, 32'd0);
        check("reset.flags", {27'd0, byte_valid, frame_start, frame_done, frame_ok, locked}, 32'd0);
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b0, 16, 16);

        for (int k = 0; k < 6; k++) begin
            clear_mon();
            tx_idx = 0;
            send_frame(vecs[k]);
            check_frame($sformatf("vec%0d", k), vecs[k]);
        end

        // Reset right after the first payload byte of a frame.
        clear_mon();
        tx_idx = 0;
        send_header(8'h02, 16, 16);
        send_byte(8'h12, 16, 16);
        check("midrst.first_byte_n", got_bytes.size(), 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("midrst.byte_out", {24'd0, byte_out}, 32'd0);
        check("midrst.flags", {27'd0, byte_valid, frame_start, frame_done, frame_ok, locked}, 32'd0);
        clear_mon();
        tx_idx = 0;
        send_frame(vecs[0]);
        check_frame("midrst.next", vecs[0]);

        // 0xD390 then random bits that never complete 0xD391.
        clear_mon();
        tx_idx = 0;
        for (int i = 0; i < 16; i++) send_bit(1'b0, 16, 16);
        fake = 16'hD390;
        win  = 16'h0000;
        for (int i = 15; i >= 0; i--) begin
            send_bit(fake[i], 16, 16);
            win = {win[14:0], fake[i]};
        end
        for (int i = 0; i < 48; i++) begin
            b = 1'($urandom_range(0, 1));
            if ({win[14:0], b} == 16'hD391) b = ~b;
            win = {win[14:0], b};
            send_bit(b, 16, 16);
        end
        check("false.start", n_start, 0);
        check("false.locked_cycles", n_locked, 0);
        check("pulse_width", n_wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
